// File: rtl/powlib_ipreqgen.sv
// IP-bus request generator: packs commands into write/read requests and collects
// in-order read returns. Define POWLIB_IPREQGEN_TAGCHK_EN to include the return-tag check.

`ifndef POWLIB_BW
`define POWLIB_BW 8
`endif
`ifndef POWLIB_OPW
`define POWLIB_OPW 4
`endif
`ifndef POWLIB_OP_WRITE
`define POWLIB_OP_WRITE 4'h0
`endif
`ifndef POWLIB_OP_READ
`define POWLIB_OP_READ 4'h1
`endif

module powlib_ipreqgen #(
  parameter int unsigned B_BPD    = 4,
  parameter int unsigned B_AW     = `POWLIB_BW * B_BPD,
  parameter int unsigned RET_BASE = 0,
  parameter int unsigned MAX_OUT  = 4,
  localparam int unsigned B_DW    = `POWLIB_BW * B_BPD,
  localparam int unsigned B_BEW   = B_BPD,
  localparam int unsigned B_OPW   = `POWLIB_OPW,
  localparam int unsigned B_WW    = B_OPW + B_BEW + B_DW,
  localparam int unsigned TAGW    = $clog2(MAX_OUT),
  localparam int unsigned CW      = $clog2(MAX_OUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [B_AW-1:0]   cmdaddr,
  input  logic [B_DW-1:0]   cmddata,
  input  logic [B_BEW-1:0]  cmdbe,
  input  logic              cmdwr,
  input  logic              cmdvld,
  output logic              cmdrdy,
  output logic [B_AW-1:0]   wraddr,
  output logic [B_WW-1:0]   wrdata,
  output logic              wrvld,
  input  logic              wrnf,
  input  logic [B_AW-1:0]   rspaddr,
  input  logic [B_WW-1:0]   rspdata,
  input  logic              rspvld,
  output logic              rsprdy,
  output logic [B_DW-1:0]   rdata,
  output logic [TAGW-1:0]   rtag,
  output logic              rvld,
  input  logic              rrdy,
  output logic              rerr,
  output logic [CW-1:0]     outstanding
);

  logic [TAGW-1:0]  itag_q;
  logic [TAGW-1:0]  etag_q;
  logic             cmd_acc;
  logic             rd_acc;
  logic             rsp_acc;
  logic             out_empty;
  logic             cnt_dec;
  logic [B_AW-1:0]  ret_addr;
  logic [B_AW-1:0]  rsp_off;
  logic [TAGW-1:0]  rsp_tag;
  logic [B_OPW-1:0] rsp_op;
  logic             tag_err;
  logic             rsp_err;

  // Reads are throttled by the outstanding budget; writes only by slave back-pressure.
  assign cmdrdy  = !rst && !wrnf && (cmdwr || (outstanding < CW'(MAX_OUT)));
  assign cmd_acc = cmdvld && cmdrdy;
  assign rd_acc  = cmd_acc && !cmdwr;

  assign rsprdy  = !rvld || rrdy;
  assign rsp_acc = rspvld && rsprdy;

  assign out_empty = (outstanding == '0);
  // An unsolicited response must not drive the counter negative.
  assign cnt_dec   = rsp_acc && !out_empty;

  assign ret_addr = B_AW'(RET_BASE) + B_AW'(itag_q);
  assign rsp_off  = rspaddr - B_AW'(RET_BASE);
  assign rsp_tag  = rsp_off[TAGW-1:0];
  assign rsp_op   = rspdata[B_WW-1 -: B_OPW];

`ifdef POWLIB_IPREQGEN_TAGCHK_EN
  assign tag_err = (rsp_tag != etag_q);
`else
  assign tag_err = 1'b0;
`endif

  // Read returns arrive as write packets aimed at our return address.
  assign rsp_err = out_empty || (rsp_op != B_OPW'(`POWLIB_OP_WRITE)) || tag_err;

  logic unused_rsp;
  assign unused_rsp = ^{rspdata[B_DW +: B_BEW], rsp_off[B_AW-1:TAGW]};

  // Request side
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrvld  <= 1'b0;
      wraddr <= '0;
      wrdata <= '0;
      itag_q <= '0;
    end else begin
      wrvld <= cmd_acc;
      if (cmd_acc) begin
        wraddr <= cmdaddr;
        if (cmdwr) begin
          wrdata <= {B_OPW'(`POWLIB_OP_WRITE), cmdbe, cmddata};
        end else begin
          wrdata <= {B_OPW'(`POWLIB_OP_READ), {B_BEW{1'b1}}, B_DW'(ret_addr)};
          itag_q <= itag_q + TAGW'(1);
        end
      end
    end
  end

  // Response side
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvld   <= 1'b0;
      rdata  <= '0;
      rtag   <= '0;
      rerr   <= 1'b0;
      etag_q <= '0;
    end else begin
      if (rsp_acc) begin
        rvld   <= 1'b1;
        rdata  <= rspdata[B_DW-1:0];
        rtag   <= rsp_tag;
        etag_q <= etag_q + TAGW'(1);
        if (rsp_err) begin
          rerr <= 1'b1;
        end
      end else if (rrdy) begin
        rvld <= 1'b0;
      end
    end
  end

  // Outstanding read counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      if (rd_acc && !cnt_dec) begin
        outstanding <= outstanding + CW'(1);
      end else if (!rd_acc && cnt_dec) begin
        outstanding <= outstanding - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_powlib_ipreqgen.sv
// Randomized bench for powlib_ipreqgen with a behavioural slave memory and a
// transaction-level reference model of requests, returns, tags and errors.

`ifndef POWLIB_BW
`define POWLIB_BW 8
`endif
`ifndef POWLIB_OPW
`define POWLIB_OPW 4
`endif
`ifndef POWLIB_OP_WRITE
`define POWLIB_OP_WRITE 4'h0
`endif
`ifndef POWLIB_OP_READ
`define POWLIB_OP_READ 4'h1
`endif

module tb_powlib_ipreqgen;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int BEW  = 4;
  localparam int OPW  = `POWLIB_OPW;
  localparam int WW   = OPW + BEW + DW;
  localparam int MAXO = 4;
  localparam int TAGW = 2;
  localparam int CW   = 3;
  localparam logic [AW-1:0] RBASE = 32'h100;
`ifdef POWLIB_IPREQGEN_TAGCHK_EN
  localparam bit TAGCHK = 1'b1;
`else
  localparam bit TAGCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0]   cmdaddr = '0;
  logic [DW-1:0]   cmddata = '0;
  logic [BEW-1:0]  cmdbe = '0;
  logic            cmdwr = 1'b0;
  logic            cmdvld = 1'b0;
  logic            cmdrdy;
  logic [AW-1:0]   wraddr;
  logic [WW-1:0]   wrdata;
  logic            wrvld;
  logic            wrnf = 1'b0;
  logic [AW-1:0]   rspaddr = '0;
  logic [WW-1:0]   rspdata = '0;
  logic            rspvld = 1'b0;
  logic            rsprdy;
  logic [DW-1:0]   rdata;
  logic [TAGW-1:0] rtag;
  logic            rvld;
  logic            rrdy = 1'b1;
  logic            rerr;
  logic [CW-1:0]   outstanding;

  powlib_ipreqgen #(
    .B_BPD    (4),
    .B_AW     (AW),
    .RET_BASE (32'h100),
    .MAX_OUT  (MAXO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmdaddr     (cmdaddr),
    .cmddata     (cmddata),
    .cmdbe       (cmdbe),
    .cmdwr       (cmdwr),
    .cmdvld      (cmdvld),
    .cmdrdy      (cmdrdy),
    .wraddr      (wraddr),
    .wrdata      (wrdata),
    .wrvld       (wrvld),
    .wrnf        (wrnf),
    .rspaddr     (rspaddr),
    .rspdata     (rspdata),
    .rspvld      (rspvld),
    .rsprdy      (rsprdy),
    .rdata       (rdata),
    .rtag        (rtag),
    .rvld        (rvld),
    .rrdy        (rrdy),
    .rerr        (rerr),
    .outstanding (outstanding)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state (values the registered outputs should hold)
  int            m_out, m_itag, m_etag, m_rtag;
  bit            m_rvld, m_rerr, m_wrvld;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] m_wraddr;
  logic [WW-1:0] m_wrdata;
  logic [DW-1:0] ref_mem [16];
  int            ref_tag_q [$];
  logic [DW-1:0] ref_dat_q [$];

  // Behavioural slave
  logic [DW-1:0]    slv_mem [16];
  logic [AW+WW-1:0] slv_q [$];
  bit               slv_en = 1'b0;
  bit               rsp_hold = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [BEW-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < BEW; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // One clock: entered just after a negedge with inputs set by the caller.
  task automatic cycle(input bit inject);
    bit            ecmd, ersp, cacc, racc, err, had;
    logic [AW-1:0] off, ra;
    int            tag_a, et, o, rt;
    logic [DW-1:0] ed, rd;
    if (!inject) begin
      if (slv_en && slv_q.size() > 0 && (rsp_hold || $urandom_range(0, 3) != 0)) begin
        {rspaddr, rspdata} = slv_q[0];
        rspvld = 1'b1;
      end else begin
        rspvld = 1'b0;
      end
    end
    #1;
    ecmd = !wrnf && (cmdwr || m_out < MAXO);
    ersp = !m_rvld || rrdy;
    chk("cmdrdy", cmdrdy, ecmd);
    chk("rsprdy", rsprdy, ersp);
    cacc = cmdvld && ecmd;
    racc = rspvld && ersp;
    o = m_out;
    m_wrvld = cacc;
    if (cacc) begin
      m_wraddr = cmdaddr;
      if (cmdwr) begin
        m_wrdata = {`POWLIB_OP_WRITE, cmdbe, cmddata};
        ref_mem[cmdaddr[3:0]] = merge(ref_mem[cmdaddr[3:0]], cmddata, cmdbe);
      end else begin
        ra = RBASE + AW'(m_itag);
        m_wrdata = {`POWLIB_OP_READ, 4'hF, ra};
        ref_tag_q.push_back(m_itag);
        ref_dat_q.push_back(ref_mem[cmdaddr[3:0]]);
        m_itag = (m_itag + 1) % MAXO;
        o++;
      end
    end
    if (racc) begin
      off = rspaddr - RBASE;
      tag_a = int'(off % MAXO);
      had = ref_tag_q.size() > 0;
      rt = 0;
      rd = '0;
      if (had) begin
        rt = ref_tag_q.pop_front();
        rd = ref_dat_q.pop_front();
      end
      if (inject || !had) begin
        et = tag_a;
        ed = rspdata[DW-1:0];
      end else begin
        et = rt;
        ed = rd;
      end
      err = (m_out == 0) || (rspdata[WW-1 -: OPW] != `POWLIB_OP_WRITE);
      if (TAGCHK && tag_a != m_etag) err = 1'b1;
      if (err) m_rerr = 1'b1;
      m_etag  = (m_etag + 1) % MAXO;
      m_rvld  = 1'b1;
      m_rdata = ed;
      m_rtag  = et;
      if (m_out > 0) o--;
      if (!inject) begin
        slv_q.delete(0);
        rsp_hold = 1'b0;
      end
    end else begin
      if (rrdy) m_rvld = 1'b0;
      if (!inject) rsp_hold = rspvld;
    end
    m_out = o;
    @(posedge clk);
    #1;
    chk("wrvld", wrvld, m_wrvld);
    chk("wraddr", wraddr, m_wraddr);
    chk("wrdata", wrdata, m_wrdata);
    chk("rvld", rvld, m_rvld);
    chk("rdata", rdata, m_rdata);
    chk("rtag", rtag, m_rtag);
    chk("rerr", rerr, m_rerr);
    chk("outstanding", outstanding, m_out);
    if (wrvld === 1'b1) begin
      if (wrdata[WW-1 -: OPW] == `POWLIB_OP_WRITE)
        slv_mem[wraddr[3:0]] = merge(slv_mem[wraddr[3:0]], wrdata[DW-1:0], wrdata[DW +: BEW]);
      else
        slv_q.push_back({wrdata[AW-1:0], `POWLIB_OP_WRITE, 4'hF, slv_mem[wraddr[3:0]]});
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input bit clr_slave);
    cmdvld = 1'b1;
    cmdwr  = 1'b1;
    wrnf   = 1'b0;
    rspvld = 1'b0;
    rrdy   = 1'b1;
    rst    = 1'b1;
    #1;
    chk("rst_wrvld", wrvld, 0);
    chk("rst_wraddr", wraddr, 0);
    chk("rst_wrdata", wrdata, 0);
    chk("rst_rvld", rvld, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rtag", rtag, 0);
    chk("rst_rerr", rerr, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_cmdrdy", cmdrdy, 0);
    chk("rst_rsprdy", rsprdy, 1);
    m_out = 0; m_itag = 0; m_etag = 0; m_rtag = 0;
    m_rvld = 0; m_rerr = 0; m_wrvld = 0;
    m_rdata = '0; m_wraddr = '0; m_wrdata = '0;
    ref_tag_q.delete();
    ref_dat_q.delete();
    if (clr_slave) slv_q.delete();
    rsp_hold = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_cmdrdy_hold", cmdrdy, 0);
    @(negedge clk);
    rst    = 1'b0;
    cmdvld = 1'b0;
  endtask

  task automatic cmd(input bit wr, input int addr, input logic [DW-1:0] data,
                     input logic [BEW-1:0] be);
    cmdvld  = 1'b1;
    cmdwr   = wr;
    cmdaddr = AW'(addr);
    cmddata = data;
    cmdbe   = be;
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      slv_mem[i] = v;
    end
    @(negedge clk);
    do_reset(1'b1);

    // Single write
    cmd(1'b1, 3, 32'hDEADBEEF, 4'hF);
    cycle(1'b0);
    chk("wr_pkt", wrdata, {`POWLIB_OP_WRITE, 4'hF, 32'hDEADBEEF});
    cmdvld = 1'b0;
    cycle(1'b0);

    // Four back-to-back reads with the slave held off, then budget exhausted
    for (int i = 0; i < 4; i++) begin
      cmd(1'b0, i, '0, '0);
      cycle(1'b0);
      chk("rd_retaddr", wrdata[DW-1:0], 32'h100 + i);
    end
    cmd(1'b0, 7, '0, '0);
    cycle(1'b0);
    chk("rd_full_block", wrvld, 0);
    cmd(1'b1, 5, 32'h0BADF00D, 4'h5);
    cycle(1'b0);
    chk("wr_when_full", wrvld, 1);
    wrnf = 1'b1;
    cmd(1'b1, 6, 32'h12345678, 4'hF);
    cycle(1'b0);
    chk("wrnf_block", wrvld, 0);
    wrnf = 1'b0;
    cmdvld = 1'b0;
    slv_en = 1'b1;
    repeat (20) cycle(1'b0);
    chk("drain_out", outstanding, 0);

    // Six reads with the consumer stalled, then released
    rrdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) cmd(1'b0, i + 2, '0, '0);
      else cmdvld = 1'b0;
      cycle(1'b0);
    end
    cmdvld = 1'b0;
    chk("stall_rsprdy", rsprdy, 0);
    rrdy = 1'b1;
    repeat (25) cycle(1'b0);
    chk("loop_out", outstanding, 0);
    chk("loop_rerr", rerr, 0);

    // Wrong tag, then unsolicited response
    slv_en = 1'b0;
    do_reset(1'b1);
    cmd(1'b0, 1, '0, '0);
    cycle(1'b0);
    cmdvld = 1'b0;
    slv_q.delete();
    rspaddr = 32'h102;
    rspdata = {`POWLIB_OP_WRITE, 4'hF, 32'hCAFE0001};
    rspvld  = 1'b1;
    cycle(1'b1);
    rspvld = 1'b0;
    chk("tag_err", rerr, TAGCHK);
    chk("tag_rtag", rtag, 2);
    cycle(1'b0);
    rspaddr = 32'h101;
    rspdata = {`POWLIB_OP_WRITE, 4'hF, 32'hCAFE0002};
    rspvld  = 1'b1;
    cycle(1'b1);
    rspvld = 1'b0;
    chk("unsolicited_err", rerr, 1);
    cycle(1'b0);

    // Bad opcode on an expected return
    do_reset(1'b1);
    cmd(1'b0, 2, '0, '0);
    cycle(1'b0);
    cmdvld = 1'b0;
    slv_q.delete();
    rspaddr = 32'h100;
    rspdata = {`POWLIB_OP_READ, 4'hF, 32'hCAFE0003};
    rspvld  = 1'b1;
    cycle(1'b1);
    rspvld = 1'b0;
    chk("op_err", rerr, 1);
    cycle(1'b0);

    // Reset with three reads in flight; stale returns afterwards are unsolicited
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      cmd(1'b0, i + 4, '0, '0);
      cycle(1'b0);
    end
    cmdvld = 1'b0;
    chk("pre_rst_out", outstanding, 3);
    do_reset(1'b0);
    chk("post_rst_out", outstanding, 0);
    slv_en = 1'b1;
    repeat (10) cycle(1'b0);
    chk("stale_err", rerr, 1);

    // Randomized traffic
    do_reset(1'b1);
    for (int n = 0; n < 400; n++) begin
      cmdvld  = ($urandom_range(0, 9) < 7);
      cmdwr   = $urandom_range(0, 1) != 0;
      cmdaddr = AW'($urandom_range(0, 15));
      cmddata = $urandom;
      cmdbe   = BEW'($urandom_range(0, 15));
      wrnf    = ($urandom_range(0, 6) == 0);
      rrdy    = ($urandom_range(0, 3) != 0);
      cycle(1'b0);
    end
    cmdvld = 1'b0;
    wrnf   = 1'b0;
    rrdy   = 1'b1;
    repeat (30) cycle(1'b0);
    chk("rand_out", outstanding, 0);
    chk("rand_rerr", rerr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
